// File: rtl/alu_pkg.sv
// Shared constants and helpers for the inc_counter block.
// Saturating mode is selected with the INC_COUNTER_SAT_EN macro in inc_counter.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 16;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Effective count modulus: MODULO, or 2^WIDTH when MODULO is 0.
   function automatic logic [32:0] eff_modulus(input int width, input int modulo);
      if (modulo == 0) begin
         return 33'd1 << width;
      end
      return 33'(modulo);
   endfunction

endpackage

// File: rtl/inc_step.sv
// Combinational next-value arithmetic for inc_counter: one STEP up or down
// modulo m, flagging when the result wraps past the top or below zero.
module inc_step
   import alu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] value,
   input  logic             dir,
   input  logic [WIDTH:0]   m,
   output logic [WIDTH-1:0] next,
   output logic             wrap
);

   localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

   logic [WIDTH:0] ext;
   logic [WIDTH:0] sum;

   // One extra bit keeps value + STEP and value + m from overflowing.
   always_comb begin
      ext  = {1'b0, value};
      sum  = '0;
      next = '0;
      wrap = 1'b0;
      if (dir == DIR_UP) begin
         sum = ext + STEP_X;
         if (sum < m) begin
            next = sum[WIDTH-1:0];
         end else begin
            next = WIDTH'(sum - m);
            wrap = 1'b1;
         end
      end else begin
         if (ext >= STEP_X) begin
            next = WIDTH'(ext - STEP_X);
         end else begin
            next = WIDTH'(ext + m - STEP_X);
            wrap = 1'b1;
         end
      end
   end

endmodule

// File: rtl/inc_counter.sv
// Loadable up/down modulo counter with a registered wrap/borrow pulse.
// Define INC_COUNTER_SAT_EN to saturate at 0 / M-1 instead of wrapping.
module inc_counter
   import alu_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int MODULO = 0,
   parameter int STEP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic             dir,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] o,
   output logic             carry_out,
   output logic             zero
);

   localparam logic [WIDTH:0] M     = (WIDTH+1)'(eff_modulus(WIDTH, MODULO));
   localparam logic [WIDTH:0] M_TOP = M - 1'b1;

   logic [WIDTH-1:0] count_q;
   logic             carry_q;
   logic [WIDTH-1:0] step_next;
   logic             step_wrap;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] load_val;

   inc_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .value (count_q),
      .dir   (dir),
      .m     (M),
      .next  (step_next),
      .wrap  (step_wrap)
   );

   // Loaded values are folded into range so the count never leaves 0..M-1.
   assign load_val = WIDTH'({1'b0, d} % M);

`ifdef INC_COUNTER_SAT_EN
   always_comb begin
      count_next = step_next;
      if (step_wrap) begin
         count_next = (dir == DIR_DOWN) ? '0 : M_TOP[WIDTH-1:0];
      end
   end
`else
   assign count_next = step_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         carry_q <= 1'b0;
      end else if (load) begin
         count_q <= load_val;
         carry_q <= 1'b0;
      end else if (en) begin
         count_q <= count_next;
         carry_q <= step_wrap;
      end else begin
         carry_q <= 1'b0;
      end
   end

   assign o         = count_q;
   assign carry_out = carry_q;
   assign zero      = (count_q == '0);

endmodule

// File: tb/tb_inc_counter.sv
// Directed and random checks of inc_counter: a default 16-bit wrap instance
// and a modulo-10 step-3 instance, both tracked by a reference model.
module tb_inc_counter;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef INC_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        load_a = 0, en_a = 0, dir_a = 0;
   logic [15:0] d_a = '0;
   logic [15:0] o_a;
   logic        c_a, z_a;

   logic        load_b = 0, en_b = 0, dir_b = 0;
   logic [15:0] d_b = '0;
   logic [15:0] o_b;
   logic        c_b, z_b;

   inc_counter #(.WIDTH(16), .MODULO(0), .STEP(1)) dut_a (
      .clk(clk), .rst(rst), .load(load_a), .en(en_a), .dir(dir_a),
      .d(d_a), .o(o_a), .carry_out(c_a), .zero(z_a)
   );

   inc_counter #(.WIDTH(16), .MODULO(10), .STEP(3)) dut_b (
      .clk(clk), .rst(rst), .load(load_b), .en(en_b), .dir(dir_b),
      .d(d_b), .o(o_b), .carry_out(c_b), .zero(z_b)
   );

   // scoreboard
   logic [17:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int mo_a = 0;
   int mo_b = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(inout int mo, output bit c, input int m, input int s,
                        input bit ld, input bit en, input bit dr, input int dv);
      int t;
      c = 1'b0;
      if (ld) begin
         mo = dv % m;
      end else if (en) begin
         if (!dr) begin
            t = mo + s;
            if (t < m) mo = t;
            else begin
               c  = 1'b1;
               mo = SAT ? m - 1 : t - m;
            end
         end else begin
            if (mo >= s) mo = mo - s;
            else begin
               c  = 1'b1;
               mo = SAT ? 0 : mo + m - s;
            end
         end
      end
   endtask

   // driver: predict from the inputs now applied, clock once, then compare
   task automatic cycle();
      bit ca, cb;
      logic [17:0] e;
      model(mo_a, ca, 65536, 1, load_a, en_a, dir_a, int'(d_a));
      exp_q.push_back({ca, mo_a == 0, mo_a[15:0]});
      model(mo_b, cb, 10, 3, load_b, en_b, dir_b, int'(d_b));
      exp_q.push_back({cb, mo_b == 0, mo_b[15:0]});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("a_o", 32'(o_a), 32'(e[15:0]));
      check("a_carry", 32'(c_a), 32'(e[17]));
      check("a_zero", 32'(z_a), 32'(e[16]));
      e = exp_q.pop_front();
      check("b_o", 32'(o_b), 32'(e[15:0]));
      check("b_carry", 32'(c_b), 32'(e[17]));
      check("b_zero", 32'(z_b), 32'(e[16]));
   endtask

   initial begin
      // reset then idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_o", 32'(o_a), 32'h0);
      check("rst_carry", 32'(c_a), 32'h0);
      check("rst_zero", 32'(z_a), 32'h1);
      check("rst_b_o", 32'(o_b), 32'h0);
      rst = 1'b0;
      cycle();

      // full wrap at the top of the 16-bit range
      load_a = 1; d_a = 16'hFFFE;
      cycle();
      load_a = 0; en_a = 1; dir_a = 0;
      cycle();
      cycle();

      // modulo-10 step-3 down count with borrows
      en_a = 0;
      load_b = 1; d_b = 16'd1;
      cycle();
      load_b = 0; en_b = 1; dir_b = 1;
      repeat (4) cycle();
      en_b = 0;

      // load wins over en
      load_a = 1; en_a = 1; d_a = 16'hAAAA;
      cycle();

      // asynchronous reset between edges
      load_a = 1; en_a = 0; d_a = 16'h1234;
      cycle();
      load_a = 0; en_a = 1; dir_a = 0;
      cycle();
      cycle();
      #3;
      rst = 1'b1;
      #1;
      check("async_o", 32'(o_a), 32'h0);
      check("async_carry", 32'(c_a), 32'h0);
      check("async_zero", 32'(z_a), 32'h1);
      check("async_b_o", 32'(o_b), 32'h0);
      mo_a = 0;
      mo_b = 0;
      #1;
      rst = 1'b0;
      cycle();

      // attempts at the top of the range (wrap, or saturate when enabled)
      load_a = 1; en_a = 0; d_a = 16'hFFFF;
      cycle();
      load_a = 0; en_a = 1; dir_a = 0;
      repeat (3) cycle();
      dir_a = 1; load_a = 1; d_a = 16'h0000;
      cycle();
      load_a = 0;
      repeat (2) cycle();

      // random mix of commands on both instances
      repeat (80) begin
         load_a = ($urandom_range(0, 7) == 0);
         en_a   = $urandom_range(0, 3) != 0;
         dir_a  = 1'($urandom_range(0, 1));
         d_a    = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 3));
         load_b = ($urandom_range(0, 7) == 0);
         en_b   = $urandom_range(0, 3) != 0;
         dir_b  = 1'($urandom_range(0, 1));
         d_b    = 16'($urandom_range(0, 65535));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inc_counter.md
INC_COUNTER -- requirements
Module: inc_counter

Interface
REQ-001 Parameter WIDTH, default 16: counter and data width in bits, legal range 2..32.
REQ-002 Parameter MODULO, default 0: count modulus; 0 means 2^WIDTH; otherwise the legal range is 2..2^WIDTH-1.
REQ-003 Parameter STEP, default 1: increment/decrement amount, legal range 1..MODULO-1 (or 2^WIDTH-1 when MODULO=0).
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port load, input, 1: when high, load d into the counter.
REQ-007 Port en, input, 1: when high, count by STEP.
REQ-008 Port dir, input, 1: 0 counts up, 1 counts down.
REQ-009 Port d, input, WIDTH: load value.
REQ-010 Port o, output, WIDTH: registered count value.
REQ-011 Port carry_out, output, 1: registered one-cycle pulse on wrap (up past the top) or borrow (down past 0).
REQ-012 Port zero, output, 1: combinational, high when o == 0.

Function
REQ-013 Priority is load > en > hold; with load and en both high, only the load takes effect and carry_out stays 0.
REQ-014 Load: o takes d mod M next cycle, where M = MODULO or 2^WIDTH; carry_out is 0.
REQ-015 Up count: if o + STEP < M, then o takes o + STEP; otherwise o takes o + STEP - M and carry_out pulses 1.
REQ-016 Down count: if o >= STEP, then o takes o - STEP; otherwise o takes o + M - STEP and carry_out pulses 1.
REQ-017 Count arithmetic uses WIDTH+1 bits internally, so no intermediate value overflows.
REQ-018 Hold (load=0, en=0): o is unchanged and carry_out is 0.
REQ-019 carry_out is high for exactly the one cycle following the wrapping edge and is never held.
REQ-020 Latency: every command is visible on o one clock edge after it is sampled.

Reset
REQ-021 While rst is high, o = 0 and carry_out = 0 immediately, regardless of clk.
REQ-022 Asserting rst mid-count discards any pending load or count; the first edge after rst deasserts is processed normally.

Configuration
REQ-023 With macro INC_COUNTER_SAT_EN defined, counting saturates instead of wrapping.
- An up count that would reach or exceed M holds o at M-1.
- A down count that would go below 0 holds o at 0.
- carry_out pulses 1 on the first saturating attempt and on every later attempt while the counter remains saturated.
REQ-024 Without INC_COUNTER_SAT_EN, the wrap behaviour of REQ-015 and REQ-016 applies, and no saturation logic is present.

Structure
REQ-025 The shared package alu_pkg holds:
- the default WIDTH constant;
- a dir encoding constant for up/down;
- a function computing the effective modulus M from WIDTH and MODULO.
REQ-026 The next-value arithmetic is a combinational sub-module, inc_step, parametrised by WIDTH and STEP. Its ports are the current value, dir and M; its outputs are the next value and the wrap flag.
REQ-027 inc_counter holds only the state register, command priority and configuration logic, and instantiates inc_step once.

Verification
REQ-028 Reset then idle: rst=1 for 2 cycles, then en=0 -> o=0x0000, carry_out=0, zero=1.
REQ-029 Full wrap (WIDTH=16, MODULO=0, STEP=1): load 0xFFFE, then en=1, dir=0 for 2 cycles.
- o goes 0xFFFF then 0x0000.
- carry_out=1 only in the cycle o=0x0000.
REQ-030 Modulo down count (MODULO=10, STEP=3): load 1, then en=1, dir=1.
- o goes 8, 5, 2, 9.
- carry_out pulses on the 1->8 step and on the 2->9 step.
REQ-031 Priority: load=1, en=1, d=0xAAAA -> o=0xAAAA, carry_out=0.
REQ-032 Async reset mid-count: counting up from 0x1234, rst pulsed between clock edges -> o=0 immediately; counting resumes from 1 after release.
REQ-033 With INC_COUNTER_SAT_EN: load 0xFFFF, en=1, dir=0 for 3 cycles -> o stays 0xFFFF and carry_out=1 in each cycle.
